// File: rtl/cov_uart_reporter.sv
// cov_uart_reporter: snapshots the coverage sum and sends it as an ASCII hex line over an 8N1 UART
module cov_uart_reporter #(
  parameter int COV_WIDTH = 32,
  parameter int CLK_DIV   = 868,
  parameter int PERIOD    = 100000000
) (
  input  logic                 clock,
  input  logic                 aresetn,
  input  logic [COV_WIDTH-1:0] io_covSum,
  input  logic                 metaReset,
  input  logic                 enable,
  input  logic                 force_report,
  output logic                 uart_txd,
  output logic                 busy,
  output logic [15:0]          report_count,
  output logic                 overrun
);
  localparam int N  = COV_WIDTH / 4;
  localparam int BW = $clog2(CLK_DIV);
  localparam int PW = $clog2(PERIOD);
  localparam int IW = $clog2(N + 4);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
  localparam logic [IW-1:0] IDX_CR    = IW'(N + 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N + 3);
  localparam logic [IW-1:0] IDX_HEX0  = IW'(2);
  localparam logic [IW-1:0] IDX_HEXN  = IW'(N + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        period_q, period_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [COV_WIDTH-1:0] snap_q, snap_d;
  logic [15:0]          count_q, count_d;
  logic                 ovr_q, ovr_d;
  logic                 trig, launch, baud_end, last_byte, is_hex;
  logic [3:0]           nib;
  logic [7:0]           hex_char, cur_byte;

  // Trigger decode and the byte currently on the wire; hex digits come from the top nibble of a shifting snapshot
  always_comb begin
    trig      = (enable && period_q == PER_LAST) || force_report;
    launch    = state_q == IDLE && trig;
    baud_end  = baud_q == BAUD_LAST;
    last_byte = idx_q == IDX_LAST;
    is_hex    = idx_q >= IDX_HEX0 && idx_q <= IDX_HEXN;
    nib       = snap_q[COV_WIDTH-1 -: 4];
    hex_char  = {4'h0, nib} + (nib < 4'd10 ? 8'h30 : 8'h37);
    cur_byte  = idx_q == '0 ? 8'h43 : idx_q == IW'(1) ? 8'h3A : is_hex ? hex_char : idx_q == IDX_CR ? 8'h0D : 8'h0A;
  end

  // State register; metaReset forces IDLE synchronously
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= metaReset ? IDLE : state_d;
  end

  // Next-state logic: each bit phase lasts one baud period, NEXT is a single cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = trig ? START : IDLE;
      START:   state_d = baud_end ? DATA : START;
      DATA:    state_d = baud_end && bit_q == 3'd7 ? STOP : DATA;
      STOP:    state_d = baud_end ? NEXT : STOP;
      default: state_d = last_byte ? IDLE : START;
    endcase
  end

  // Datapath next values: period timer, baud/bit/byte counters, snapshot, report count and sticky overrun
  always_comb begin
    period_d = !enable || trig ? '0 : period_q + 1'b1;
    baud_d   = state_q inside {START, DATA, STOP} && !baud_end ? baud_q + 1'b1 : '0;
    bit_d    = state_q == DATA && baud_end ? bit_q + 1'b1 : bit_q;
    idx_d    = launch ? '0 : state_q == NEXT ? idx_q + 1'b1 : idx_q;
    snap_d   = launch ? io_covSum : state_q == NEXT && is_hex ? snap_q << 4 : snap_q;
    count_d  = state_q == NEXT && last_byte ? count_q + 1'b1 : count_q;
    ovr_d    = ovr_q || (trig && state_q != IDLE);
  end

  // Datapath registers; metaReset clears everything an abort must forget
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      period_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else if (metaReset) begin
      period_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // Outputs decode from registered state so the async reset reaches them immediately
  always_comb begin
    uart_txd     = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
    busy         = state_q != IDLE;
    report_count = count_q;
    overrun      = ovr_q;
  end
endmodule

// File: tb/tb_cov_uart_reporter.sv
// tb_cov_uart_reporter: directed bench with a timeline model of the serial line and a UART decoder
module tb_cov_uart_reporter;
  localparam int CW = 32;
  localparam int DIV = 4;
  localparam int PER = 1000;
  localparam int BYTE_T = 10 * DIV + 1;
  localparam int NBYTES = CW / 4 + 4;
  localparam int FRAME = NBYTES * BYTE_T;

  logic          clock = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] io_covSum = '0;
  logic          metaReset = 1'b0;
  logic          enable = 1'b0;
  logic          force_report = 1'b0;
  logic          uart_txd, busy, overrun;
  logic [15:0]   report_count;

  int n_cmp = 0;
  int n_bad = 0;

  cov_uart_reporter #(.COV_WIDTH(CW), .CLK_DIV(DIV), .PERIOD(PER)) dut (
    .clock(clock), .aresetn(aresetn), .io_covSum(io_covSum), .metaReset(metaReset),
    .enable(enable), .force_report(force_report), .uart_txd(uart_txd), .busy(busy),
    .report_count(report_count), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] line_byte(input logic [CW-1:0] v, input int b);
    logic [3:0] d;
    if (b == 0) return 8'h43;
    if (b == 1) return 8'h3A;
    if (b == NBYTES - 2) return 8'h0D;
    if (b == NBYTES - 1) return 8'h0A;
    d = 4'(v >> (4 * (NBYTES - 3 - b)));
    return d < 10 ? 8'h30 + 8'(d) : 8'h41 + 8'(d) - 8'd10;
  endfunction

  function automatic logic line_bit(input logic [CW-1:0] v, input int t);
    int r;
    logic [7:0] c;
    r = t % BYTE_T;
    c = line_byte(v, t / BYTE_T);
    if (r < DIV) return 1'b0;
    if (r < 9 * DIV) return c[(r - DIV) / DIV];
    return 1'b1;
  endfunction

  // Behavioural model: a message is a timeline of FRAME cycles starting at the trigger edge
  logic          m_active = 1'b0, m_ovr = 1'b0;
  int            m_t = 0, m_per = 0, m_cnt = 0;
  logic [CW-1:0] m_line = '0;
  wire           m_trig = (enable && m_per == PER - 1) || force_report;

  always @(posedge clock or negedge aresetn) begin
    if (!aresetn || metaReset) begin
      m_active <= 1'b0;
      m_ovr    <= 1'b0;
      m_per    <= 0;
      m_cnt    <= 0;
      m_t      <= 0;
    end else begin
      m_per <= (!enable || m_trig) ? 0 : m_per + 1;
      if (m_active) begin
        if (m_trig) m_ovr <= 1'b1;
        if (m_t == FRAME - 1) begin
          m_active <= 1'b0;
          m_cnt    <= (m_cnt + 1) % 65536;
        end
        m_t <= m_t + 1;
      end else if (m_trig) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_line   <= io_covSum;
      end
    end
  end

  always @(negedge clock) begin
    check("txd", uart_txd, m_active ? line_bit(m_line, m_t) : 1'b1);
    check("busy", busy, m_active);
    check("count", report_count, 16'(m_cnt));
    check("overrun", overrun, m_ovr);
  end

  // UART receiver sampling each bit mid-period
  logic [7:0] rx[$];
  logic [7:0] rx_b;
  initial forever begin
    @(negedge clock);
    if (aresetn === 1'b1 && uart_txd === 1'b0) begin
      repeat (DIV + DIV / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        rx_b[i] = uart_txd;
        repeat (DIV) @(negedge clock);
      end
      if (uart_txd === 1'b1) rx.push_back(rx_b);
    end
  end

  task automatic check_line(input string name, input string exp);
    check({name, "_len"}, 64'(rx.size()), 64'(exp.len()));
    for (int i = 0; i < exp.len() && i < rx.size(); i++)
      check($sformatf("%s[%0d]", name, i), rx[i], exp[i]);
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string name, output int n);
    n = 0;
    while (busy !== lvl && n < max) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (busy !== lvl) check({name, "_timeout"}, busy, lvl);
  endtask

  task automatic pulse_force(input logic [CW-1:0] v);
    io_covSum = v;
    force_report = 1'b1;
    @(posedge clock);
    #2;
    force_report = 1'b0;
  endtask

  task automatic idle_cycles(input int k, output int lows);
    lows = 0;
    repeat (k) begin
      @(posedge clock);
      #2;
      if (uart_txd !== 1'b1) lows++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    string s;
    repeat (3) @(posedge clock);
    #2;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", report_count, 16'd0);
    check("rst_ovr", overrun, 1'b0);

    // periodic trigger fires on the 1000th edge after release
    aresetn = 1'b1;
    enable = 1'b1;
    io_covSum = 32'h00C0FFEE;
    wait_busy(1'b1, 1100, "t1_rise", n);
    check("t1_trig_edge", n, 1000);
    wait_busy(1'b0, 600, "t1_fall", n);
    check("t1_busy_len", n, 492);
    enable = 1'b0;
    check("t1_count", report_count, 16'd1);
    check("t1_ovr", overrun, 1'b0);
    s = "C:00C0FFEE\r\n";
    check_line("t1_line", s);
    rx.delete();

    // snapshot isolates the message from later input changes
    repeat (5) @(posedge clock);
    #2;
    pulse_force(32'h12345678);
    repeat (100) @(posedge clock);
    #2;
    io_covSum = 32'hFFFFFFFF;
    wait_busy(1'b0, 600, "t2_fall", n);
    check("t2_remaining", n, 392);
    s = "C:12345678\r\n";
    check_line("t2_line", s);
    check("t2_count", report_count, 16'd2);
    rx.delete();

    // trigger while busy is dropped but flagged
    pulse_force(32'h0BADF00D);
    repeat (50) @(posedge clock);
    #2;
    pulse_force(32'h11111111);
    check("t3_ovr_busy", overrun, 1'b1);
    wait_busy(1'b0, 600, "t3_fall", n);
    idle_cycles(60, n);
    check("t3_no_extra", n, 0);
    check("t3_ovr_sticky", overrun, 1'b1);
    check("t3_count", report_count, 16'd3);
    s = "C:0BADF00D\r\n";
    check_line("t3_line", s);

    // metaReset during byte 5 aborts and clears
    pulse_force(32'hDEADBEEF);
    repeat (5 * BYTE_T + 10) @(posedge clock);
    #2;
    check("t4_busy_before", busy, 1'b1);
    metaReset = 1'b1;
    @(posedge clock);
    #2;
    metaReset = 1'b0;
    check("t4_txd", uart_txd, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_count", report_count, 16'd0);
    check("t4_ovr", overrun, 1'b0);
    idle_cycles(100, n);
    check("t4_quiet", n, 0);
    rx.delete();

    // disabled: no periodic report, then force starts immediately
    enable = 1'b0;
    idle_cycles(2000, n);
    check("t5_quiet", n, 0);
    pulse_force(32'hA5A5A5A5);
    check("t5_start_bit", uart_txd, 1'b0);
    check("t5_busy", busy, 1'b1);
    wait_busy(1'b0, 600, "t5_fall", n);
    s = "C:A5A5A5A5\r\n";
    check_line("t5_line", s);
    check("t5_count", report_count, 16'd1);
    rx.delete();

    // async reset in the middle of the first stop bit
    pulse_force(32'h55AA55AA);
    repeat (37) @(posedge clock);
    #1;
    check("t6_pre_count", report_count, 16'd1);
    aresetn = 1'b0;
    #1;
    check("t6_txd", uart_txd, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_count", report_count, 16'd0);
    repeat (3) @(posedge clock);
    #2;
    aresetn = 1'b1;
    idle_cycles(20, n);
    check("t6_quiet", n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
